// File: rtl/kara32_sched.sv
// Karatsuba sequencer: runs three 17x17 sub-products of a 32x32 unsigned
// multiply through one shared multiplier and recombines them into 64 bits.
module kara32_sched #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [63:0] P,
    output logic        err,
    output logic        m_start,
    output logic [16:0] m_A,
    output logic [16:0] m_B,
    input  logic        m_done,
    input  logic [33:0] m_P
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RELEASE,
        S_COMBINE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [33:0]        z0_q, z0_d, z1_q, z1_d, z2_q, z2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               abort_q, abort_d;
    logic [63:0]        p_q, p_d;
    logic               err_q, err_d;
    logic [16:0]        ma_q, ma_d, mb_q, mb_d;
    logic [33:0]        mid;
    logic [1:0]         k_nxt;

    // Operand pair for sub-product k: {opA, opB}; k=2 uses the 17-bit half sums.
    function automatic logic [33:0] sel_ops(input logic [1:0] k,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (k)
            2'd0:    sel_ops = {1'b0, a[15:0], 1'b0, b[15:0]};
            2'd1:    sel_ops = {1'b0, a[31:16], 1'b0, b[31:16]};
            default: sel_ops = {({1'b0, a[15:0]} + {1'b0, a[31:16]}),
                                ({1'b0, b[15:0]} + {1'b0, b[31:16]})};
        endcase
    endfunction

    assign cnt_inc = cnt_q + 1'b1;
    assign k_nxt   = k_q + 2'd1;
    assign mid     = z1_q - z2_q - z0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            z0_q    <= '0;
            z1_q    <= '0;
            z2_q    <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            p_q     <= '0;
            err_q   <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
            z2_q    <= z2_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            p_q     <= p_d;
            err_q   <= err_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        z0_d    = z0_q;
        z1_d    = z1_q;
        z2_d    = z2_q;
        cnt_d   = cnt_q;
        abort_d = abort_q;
        p_d     = p_q;
        err_d   = err_q;
        ma_d    = ma_q;
        mb_d    = mb_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d            = A;
                    b_d            = B;
                    err_d          = 1'b0;
                    abort_d        = 1'b0;
                    k_d            = 2'd0;
                    cnt_d          = '0;
                    {ma_d, mb_d}   = sel_ops(2'd0, A, B);
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_inc;
                if (m_done) begin
                    case (k_q)
                        2'd0:    z0_d = m_P;
                        2'd1:    z2_d = m_P;
                        default: z1_d = m_P;
                    endcase
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (TIMEOUT != 0 && cnt_inc == TO_CNT) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // Wait for the multiplier to drop done before the next request.
                if (!m_done) begin
                    if (abort_q) begin
                        abort_d = 1'b0;
                        p_d     = '0;
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (k_q < 2'd2) begin
                        k_d          = k_nxt;
                        {ma_d, mb_d} = sel_ops(k_nxt, a_q, b_q);
                        state_d      = S_ISSUE;
                    end else begin
                        state_d = S_COMBINE;
                    end
                end
            end
            S_COMBINE: begin
                p_d     = ({30'd0, z2_q} << 32) + ({30'd0, mid} << 16) + {30'd0, z0_q};
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign m_start = (state_q == S_ISSUE);
    assign m_A     = ma_q;
    assign m_B     = mb_q;
    assign P       = p_q;
    assign err     = err_q;

endmodule

// File: tb/tb_kara32_sched.sv
// Scoreboard bench for kara32_sched with a behavioural single-cycle mult17.
module tb_kara32_sched;

    logic        clk, rst, start;
    logic [31:0] A, B;
    logic        busy, done, err, m_start, m_done;
    logic [63:0] P;
    logic [16:0] m_A, m_B;
    logic [33:0] m_P;

    logic        md_q, tie0, b2b;
    logic [33:0] mp_q;
    logic [63:0] exp_p_next;
    logic        exp_err_next;

    typedef struct {
        logic [63:0] p;
        logic        err;
        int          acc;
        int          lat;
        int          rises;
    } exp_t;
    exp_t q[$];

    int n_pass = 0, n_tot = 0, cyc = 0, n_acc = 0;
    int rises = 0, run = 0, last_b2b_done = 0;
    logic prev_ms = 1'b0;

    kara32_sched #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .busy(busy), .done(done), .P(P), .err(err),
        .m_start(m_start), .m_A(m_A), .m_B(m_B),
        .m_done(m_done), .m_P(m_P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level-handshake multiplier: done rises one cycle after start, falls after start drops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_q <= 1'b0;
            mp_q <= '0;
        end else if (m_start && !md_q) begin
            mp_q <= 34'(m_A) * 34'(m_B);
            md_q <= 1'b1;
        end else if (!m_start) begin
            md_q <= 1'b0;
        end
    end
    assign m_done = tie0 ? 1'b0 : md_q;
    assign m_P    = mp_q;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Monitor / scoreboard: all sampling on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                rises   = 0;
                run     = 0;
                prev_ms = 1'b0;
            end else begin
                if (m_start && !prev_ms) begin
                    rises++;
                    chk("mstart_rise_with_mdone_low", 64'(m_done), 64'd0);
                end
                if (m_start) run++;
                else if (prev_ms) begin
                    chk("issue_cycles", 64'(run), tie0 ? 64'd8 : 64'd2);
                    run = 0;
                end
                prev_ms = m_start;

                if (done) begin
                    if (q.size() == 0) begin
                        chk("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("P", P, e.p);
                        chk("err", 64'(err), 64'(e.err));
                        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                        chk("mstart_rises", 64'(rises), 64'(e.rises));
                    end
                    if (b2b) begin
                        if (last_b2b_done != 0)
                            chk("done_spacing", 64'(cyc - last_b2b_done), 64'd15);
                        last_b2b_done = cyc;
                    end
                end

                if (start && !busy) begin
                    e.p     = exp_p_next;
                    e.err   = exp_err_next;
                    e.acc   = cyc;
                    e.lat   = exp_err_next ? 10 : 14;
                    e.rises = exp_err_next ? 1 : 3;
                    q.push_back(e);
                    rises = 0;
                    n_acc++;
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] ep, input logic ee);
        @(posedge clk); #1;
        A = a; B = b; exp_p_next = ep; exp_err_next = ee; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_mstart"}, 64'(m_start), 64'd0);
        chk({tag, "_P"}, P, 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_mA"}, 64'(m_A), 64'd0);
        chk({tag, "_mB"}, 64'(m_B), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        tie0 = 1'b0; b2b = 1'b0; exp_p_next = '0; exp_err_next = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // First op with explicit busy-from-cycle-1 check.
        @(posedge clk); #1;
        A = 32'h3; B = 32'h5; exp_p_next = 64'hF; exp_err_next = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("busy_cycle1", 64'(busy), 64'd1);
        drain();

        run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0);
        run_op(32'h0001_0001, 32'h0001_0001, 64'h0000_0001_0002_0001, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 1'b0);

        // Start held high; operands change every cycle, including while busy.
        b2b = 1'b1;
        begin
            int budget = 0;
            int base = n_acc;
            @(posedge clk); #1;
            start = 1'b1;
            while (n_acc - base < 50 && budget < 2000) begin
                A = $urandom; B = $urandom;
                if (budget % 7 == 0) A = 32'hFFFF_FFFF;
                exp_p_next = {32'd0, A} * {32'd0, B};
                @(posedge clk); #1;
                budget++;
            end
            start = 1'b0;
            if (budget >= 2000) chk("b2b_timeout", 64'd1, 64'd0);
        end
        drain();
        b2b = 1'b0;

        // Multiplier never answers: timeout path.
        tie0 = 1'b1;
        run_op(32'hDEAD_BEEF, 32'h0000_0007, 64'd0, 1'b1);
        tie0 = 1'b0;
        run_op(32'h0000_0100, 32'h0000_0100, 64'h0000_0000_0001_0000, 1'b0);

        // Reset in cycle 6 of an op aborts it with no done.
        @(posedge clk); #1;
        A = 32'hCAFE_0001; B = 32'h0000_FFFF; exp_p_next = 64'd0; exp_err_next = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_zero_outputs("midreset");
        @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        run_op(32'h0000_FFFF, 32'h0001_0000, 64'h0000_FFFF_0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d", n_pass, n_tot);
        $fatal(1);
    end

endmodule

// File: doc/kara32_sched.md
Name: kara32_sched

Overview:
- Sequences one shared 17x17 multiplier through the three Karatsuba sub-products of a 32x32 unsigned multiply and combines them into a 64-bit product.
- Sits between a 32-bit operand requester and a single mult17 instance, and owns that instance's start/done handshake.
- Replaces three parallel multipliers with one multiplier and a small FSM, at the cost of latency.

Parameters:
TIMEOUT, 255, max cycles to wait for m_done high in ISSUE; 0 disables timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
A  in  32  unsigned operand, captured when start accepted
B  in  32  unsigned operand, captured when start accepted
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, result valid
P  out  64  product; held until next accepted start
err  out  1  set with done when a sub-product timed out; cleared on next accepted start
m_start  out  1  level start to multiplier
m_A  out  17  multiplier operand A
m_B  out  17  multiplier operand B
m_done  in  1  multiplier done level
m_P  in  34  multiplier product

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, err, m_start = 0; P, m_A, m_B, captured halves, z0/z1/z2, counter = 0. Reset mid-operation aborts the operation with no done pulse.
- Split: AL=A[15:0], AH=A[31:16], BL=B[15:0], BH=B[31:16].
- Product order: k=0: z0=AL*BL. k=1: z2=AH*BH. k=2: z1=(AL+AH)*(BL+BH), with the sums 17 bits wide (zero-extended).
- m_A/m_B are driven from registers and are stable for the whole time m_start=1. m_start=1 exactly when state==ISSUE.
- FSM:
  - IDLE: start=1 -> capture A/B, clear err, k=0, go ISSUE. start while busy is ignored (no queueing).
  - ISSUE: m_start=1, counter increments each cycle.
    - m_done=1 -> latch m_P into z[k], clear counter, go RELEASE.
    - Counter reaches TIMEOUT (TIMEOUT!=0) -> set abort flag, clear counter, go RELEASE.
  - RELEASE: m_start=0; wait for m_done=0.
    - Then, if abort, go DONE.
    - Else if k<2, k++ and go ISSUE.
    - Else go COMBINE.
  - COMBINE: mid = z1 - z2 - z0 (34-bit, never negative). P <= (z2<<32) + (mid<<16) + z0, all 64-bit unsigned. Go DONE.
  - DONE: done=1 for exactly one cycle. On abort, P<=0 and err=1. Go IDLE. A start in this cycle is ignored; the earliest restart is the next cycle.
- Never re-assert m_start before m_done has been observed low. This guarantees the multiplier's busy flag is cleared between products.
- Latency with the single-cycle multiplier:
  - start sampled at edge 0; ISSUE at cycles 1, 5, 9 (4 cycles per product); COMBINE at cycle 13; done=1 in cycle 14.
  - Back-to-back throughput: one product per 15 cycles.
- Overflow: none. The intermediate sums fit 17 bits, z1 fits 34 bits, and P fits 64 bits.
- m_done already high on entry to ISSUE (stale) cannot happen by construction. If it does, it is treated as done.

Test Plan:
- A=0x00000003, B=0x00000005, start pulse -> busy=1 from cycle 1; done=1 at cycle 14 with P=0x000000000000000F, err=0; exactly three m_start rising edges, each with a m_done low gap before the next.
- A=0x00010000, B=0x00010000 -> P=0x0000000100000000. A=0x00010001, B=0x00010001 -> P=0x0000000100020001. Checks that z2 and the middle term are placed correctly.
- A=B=0xFFFFFFFF -> sub-products z0=0xFFFE0001, z2=0xFFFE0001, z1=0x3FFF80004; P=0xFFFFFFFE00000001, with no truncation.
- Start held high continuously with random A/B for 50 ops -> each P matches A*B; start ignored while busy and in the DONE cycle; done spacing is exactly 15 cycles.
- TIMEOUT=8, m_done tied 0 -> after 8 ISSUE cycles m_start drops; done=1 with err=1 and P=0; the next normal op clears err.
- rst asserted in cycle 6 of an op -> all outputs 0 immediately; no done pulse; a new start after reset produces a correct result.
